// File: rtl/sram_word_controller_if.sv
// Word request bus between the memory stage (master) and the SRAM word controller (slave).
// ready is combinational from the slave: low means "hold the request stable", high means idle or done.
interface sram_word_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_word_controller.sv
// Splits each 32-bit word request into two paced 16-bit accesses on an asynchronous SRAM:
// the low halfword first, then the high halfword. ready stays low until the word is complete.
module sram_word_controller #(
  parameter logic [31:0] BASE_ADDR    = 32'd1024,
  parameter int unsigned PHASE_CYCLES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  sram_word_controller_if.slave       bus,
  inout  wire  [15:0]                 SRAM_DQ,
  output logic [17:0]                 SRAM_ADDR,
  output logic                        SRAM_WE_N,
  output logic                        SRAM_OE_N,
  output logic                        SRAM_CE_N,
  output logic                        SRAM_UB_N,
  output logic                        SRAM_LB_N,
  output logic [1:0]                  state_dbg,
  output logic [3:0]                  count_dbg,
  output logic                        dq_oe_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_COUNT = 4'(PHASE_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  count;
  logic        op_wr;
  logic [16:0] word;
  logic [31:0] wdata;
  logic [31:0] rdata_q;
  logic [17:0] sram_addr_q;
  logic        request;
  logic        in_phase;
  logic        phase_last;
  logic        dq_oe;
  logic [15:0] dq_out;
  logic [18:0] offset;
  logic        unused_addr_bits;

  assign request    = bus.wr_en | bus.rd_en;
  assign in_phase   = (state == LO) || (state == HI);
  assign phase_last = (count == LAST_COUNT);

  // Only bits [18:0] matter: the word index wraps modulo 2^17 and the byte offset is dropped.
  assign offset           = bus.address[18:0] - BASE_ADDR[18:0];
  assign unused_addr_bits = &{1'b0, bus.address[31:19], offset[1:0]};

  // State register and phase counter; the counter restarts on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      if ((state_next == state) && in_phase) count <= count + 4'd1;
      else                                   count <= 4'd0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (request)    state_next = LO;
      LO:      if (phase_last) state_next = HI;
      HI:      if (phase_last) state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Request capture, SRAM address register and read data assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr       <= 1'b0;
      word        <= 17'd0;
      wdata       <= 32'd0;
      rdata_q     <= 32'd0;
      sram_addr_q <= 18'd0;
    end else begin
      if ((state == IDLE) && request) begin
        op_wr       <= bus.wr_en;
        word        <= offset[18:2];
        wdata       <= bus.write_data;
        sram_addr_q <= {offset[18:2], 1'b0};
      end
      if ((state == LO) && phase_last) sram_addr_q <= {word, 1'b1};
      if (!op_wr && phase_last) begin
        if (state == LO) rdata_q[15:0]  <= SRAM_DQ;
        if (state == HI) rdata_q[31:16] <= SRAM_DQ;
      end
    end
  end

  // WE_N rises on the last cycle of a write phase while DQ stays driven, giving data hold.
  always_comb begin
    bus.ready = (state == IDLE) ? ~request : (state == DONE);
    SRAM_CE_N = ~in_phase;
    SRAM_UB_N = ~in_phase;
    SRAM_LB_N = ~in_phase;
    SRAM_OE_N = ~(in_phase & ~op_wr);
    SRAM_WE_N = ~(in_phase & op_wr & ~phase_last);
    dq_oe     = in_phase & op_wr;
    dq_out    = (state == HI) ? wdata[31:16] : wdata[15:0];
  end

  assign SRAM_DQ       = dq_oe ? dq_out : 16'bz;
  assign SRAM_ADDR     = sram_addr_q;
  assign bus.read_data = rdata_q;
  assign state_dbg     = state;
  assign count_dbg     = count;
  assign dq_oe_dbg     = dq_oe;

endmodule

// File: tb/tb_sram_word_controller.sv
// Bench for sram_word_controller: directed and random word transactions against a word-level
// memory model, with an SRAM device model on the pins and a queue-based completion monitor.
module tb_sram_word_controller;

  localparam int PC = 3;

  typedef struct packed {
    logic        is_wr;
    logic [17:0] lo_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
  logic [1:0]  state_dbg;
  logic [3:0]  count_dbg;
  logic        dq_oe_dbg;

  sram_word_controller_if bus ();

  sram_word_controller #(.BASE_ADDR(32'd1024), .PHASE_CYCLES(PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_OE_N (sram_oe_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n),
    .state_dbg (state_dbg),
    .count_dbg (count_dbg),
    .dq_oe_dbg (dq_oe_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM device model ----------------
  logic [15:0] sram_mem [0:262143];
  initial for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
  assign sram_dq = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0) ? sram_mem[sram_addr] : 16'bz;
  always @(posedge sram_we_n) if (sram_ce_n === 1'b0) sram_mem[sram_addr] <= sram_dq;

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] ref_mem [logic [16:0]];
  logic [31:0] ref_rd;
  exp_t        exp_q[$];
  int          checks;
  int          passed;

  function automatic logic [16:0] word_of(input logic [31:0] a);
    return 17'((a - 32'd1024) / 32'd4);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  task automatic model_issue(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t        e;
    logic [16:0] w;
    w         = word_of(addr);
    e.lo_addr = {w, 1'b0};
    e.is_wr   = wr;
    e.wdata   = wr ? data : 32'd0;
    if (wr) ref_mem[w] = data;
    else    ref_rd = ref_mem.exists(w) ? ref_mem[w] : 32'd0;
    e.rdata   = ref_rd;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int   low_cnt, ph_cnt;
  bit   addr_ok, pins_ok, prev_ready;
  bit   mon_hi, mon_last;
  exp_t cur;

  initial begin
    low_cnt = 0; ph_cnt = 0; addr_ok = 1; pins_ok = 1; prev_ready = 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      low_cnt = 0; ph_cnt = 0; addr_ok = 1; pins_ok = 1; prev_ready = 1;
    end else begin
      if (!bus.ready) begin
        low_cnt++;
        if (sram_ce_n === 1'b0) begin
          if (exp_q.size() == 0) pins_ok = 0;
          else begin
            cur      = exp_q[0];
            mon_hi   = (ph_cnt >= PC);
            mon_last = ((ph_cnt % PC) == PC - 1);
            if (sram_addr !== (cur.lo_addr | 18'(mon_hi))) addr_ok = 0;
            if (sram_ub_n !== 1'b0 || sram_lb_n !== 1'b0) pins_ok = 0;
            if (cur.is_wr) begin
              if (sram_oe_n !== 1'b1 || sram_we_n !== mon_last || dq_oe_dbg !== 1'b1 ||
                  sram_dq !== (mon_hi ? cur.wdata[31:16] : cur.wdata[15:0])) pins_ok = 0;
            end else begin
              if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || dq_oe_dbg !== 1'b0) pins_ok = 0;
            end
          end
          ph_cnt++;
        end
      end else if (!prev_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("latency", 32'(low_cnt), 32'(2 * PC + 1));
          check("phase_cycles", 32'(ph_cnt), 32'(2 * PC));
          check("sram_addr_seq", 32'(addr_ok), 32'd1);
          check("phase_pins", 32'(pins_ok), 32'd1);
          check("done_pins", 32'({sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, dq_oe_dbg}),
                32'b111110);
          check("read_data", bus.read_data, cur.rdata);
        end
        low_cnt = 0; ph_cnt = 0; addr_ok = 1; pins_ok = 1;
      end
      prev_ready = bus.ready;
    end
  end

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the edge that leaves DONE.
  task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input bit drop, input bit keep);
    bit done;
    bus.wr_en      = wr;
    bus.rd_en      = rd;
    bus.address    = addr;
    bus.write_data = data;
    model_issue(wr, addr, data);
    if (drop) begin
      @(posedge clk); #1;
      bus.wr_en      = 1'b0;
      bus.rd_en      = 1'b0;
      bus.address    = $urandom;
      bus.write_data = $urandom;
    end
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.ready) done = 1;
    end
    check("txn_complete", 32'(done), 32'd1);
    @(posedge clk); #1;
    if (!keep) begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          sel;
    int          wi;
    bit          wr, rd;
    logic [31:0] a;
    checks = 0; passed = 0; ref_rd = 32'd0;
    rst = 1'b0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = 32'd0; bus.write_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_ready", 32'(bus.ready), 32'd1);
    check("idle_ctrl", 32'({sram_we_n, sram_oe_n, sram_ce_n}), 32'b111);
    check("idle_dq_oe", 32'(dq_oe_dbg), 32'd0);
    check("idle_read_data", bus.read_data, 32'd0);
    check("idle_state", 32'(state_dbg), 32'd0);
    check("idle_sram_addr", 32'(sram_addr), 32'd0);
    @(posedge clk); #1;

    do_txn(1, 0, 32'd1024, 32'hDEADBEEF, 0, 0);
    do_txn(1, 0, 32'd1032, 32'h12345678, 0, 0);
    do_txn(0, 1, 32'd1032, 32'h0, 0, 0);
    // back-to-back read then write, request held continuously
    do_txn(0, 1, 32'd1024, 32'h0, 0, 1);
    do_txn(1, 0, 32'd1028, 32'h0BADF00D, 0, 0);
    // both enables high: write wins; below-base address wraps to the top word
    do_txn(1, 1, 32'd1020, 32'hA5A55A5A, 0, 0);
    do_txn(0, 1, 32'd1023, 32'h0, 0, 0);
    do_txn(0, 1, 32'd1029, 32'h0, 1, 0);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      wr  = (sel < 4) || (sel == 9);
      rd  = (sel >= 4);
      wi  = int'($urandom_range(0, 15)) - 2;
      a   = 32'(1024 + 4 * wi) + 32'($urandom_range(0, 3));
      do_txn(wr, rd, a, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end

    // reset during the high phase of a write
    bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.address = 32'd1036; bus.write_data = 32'hCAFEF00D;
    repeat (PC + 1) @(posedge clk);
    #1;
    check("pre_reset_state_hi", 32'(state_dbg), 32'd2);
    rst = 1'b0;
    ref_rd = 32'd0;
    @(negedge clk);
    check("abort_state", 32'(state_dbg), 32'd0);
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_dq_oe", 32'(dq_oe_dbg), 32'd0);
    check("abort_read_data", bus.read_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    do_txn(1, 0, 32'd1036, 32'hCAFEF00D, 0, 0);
    do_txn(0, 1, 32'd1036, 32'h0, 0, 0);
    do_txn(0, 1, 32'd1024, 32'h0, 0, 0);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sram_word_controller.md
Name: sram_word_controller

Overview:
- Sits directly downstream of the memory stage; turns its single-cycle 32-bit word read/write requests into paced accesses on the board's external 16-bit asynchronous SRAM.
- Each word takes two halfword phases: low half first, then high half.
- Drives `ready` low for the whole transaction. The pipeline uses `~ready` to freeze the fetch, decode and execute stages and the status register, so the request stays stable until completion.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0; subtracted from every request address.
- PHASE_CYCLES, 3: clock cycles per halfword phase; legal range 2..15.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset; forces IDLE immediately.
- wr_en  input  1  word write request, level, from memory stage.
- rd_en  input  1  word read request, level, from memory stage.
- address  input  32  byte address of the word.
- write_data  input  32  word to store.
- read_data  output  32  last word read.
- ready  output  1  high = no transaction pending or transaction complete this cycle.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM halfword address.
- SRAM_WE_N  output  1  write enable, active low.
- SRAM_OE_N  output  1  output enable, active low.
- SRAM_CE_N  output  1  chip enable, active low.
- SRAM_UB_N  output  1  upper byte enable, active low.
- SRAM_LB_N  output  1  lower byte enable, active low.

Behaviour:
- Reset values, while rst=0 and on release:
  - state IDLE, counter 0, read_data 0.
  - SRAM_ADDR 0; SRAM_WE_N, OE_N, CE_N, UB_N, LB_N all 1; SRAM_DQ high-Z.
  - ready follows the IDLE rule.
- States: IDLE, LO, HI, DONE. The 4-bit phase counter clears on every state change.
- IDLE:
  - ready = ~(wr_en|rd_en), combinational, so it drops in the same cycle the request appears.
  - On a request, latch at the clock edge:
    - op: write if wr_en, else read; wr_en wins if both are high.
    - word = (address - BASE_ADDR)[18:2] (17 bits). Bits [1:0] are ignored; underflow or overflow wraps modulo 2^17 words.
    - write_data.
  - Then go to LO.
- LO: SRAM_ADDR = {word,1'b0}. Go to HI when counter = PHASE_CYCLES-1; otherwise counter+1.
- HI: SRAM_ADDR = {word,1'b1}. Go to DONE when counter = PHASE_CYCLES-1.
- DONE:
  - ready = 1 for exactly one cycle; the pipeline advances at this edge.
  - Unconditionally go to IDLE; a still-asserted request is treated as a new request there.
- ready is 0 in LO and HI.
- Latency: ready low for 2*PHASE_CYCLES+1 cycles, high in the following cycle (7 low, 8th high at default).
- In LO/HI:
  - CE_N=0, UB_N=0, LB_N=0.
  - Write: OE_N=1. DQ drives write_data[15:0] in LO, [31:16] in HI. WE_N=0 on all cycles of the phase except the last (counter = PHASE_CYCLES-1), where WE_N=1 while DQ stays driven, giving a data-hold edge.
  - Read: WE_N=1, OE_N=0, DQ high-Z. On the last cycle of LO, read_data[15:0] <= SRAM_DQ; on the last cycle of HI, read_data[31:16] <= SRAM_DQ.
- IDLE/DONE: CE_N, OE_N, WE_N, UB_N, LB_N = 1; DQ high-Z; SRAM_ADDR holds its last value.
- read_data holds between reads and is unchanged by writes.
- Inputs are ignored outside IDLE; a request dropped mid-transaction still completes.
- Reset asserted mid-transaction aborts immediately. The SRAM write may be partial; read_data is cleared.
- DQ is never driven while OE_N=0.

Test Plan:
- Reset, then 10 idle cycles -> ready=1, WE_N/OE_N/CE_N=1, DQ=Z, read_data=0.
- wr_en=1, address=1024, data=0xDEADBEEF -> ready low 7 cycles; SRAM_ADDR 0 with DQ=0xBEEF, then 1 with DQ=0xDEAD; WE_N pulses low 2 cycles per phase; ready high cycle 8.
- Write 0x12345678 to address 1032, then rd_en at 1032 with a bench SRAM model -> SRAM_ADDR 4 then 5, OE_N low, read_data=0x12345678 at ready.
- Back-to-back read then write held continuously -> ready pattern 0x7,1,0x7,1; second transaction starts in the cycle after DONE; no DQ drive during read phases.
- wr_en and rd_en both high -> write performed, read_data unchanged; address=1020 -> word wraps to 0x1FFFF, SRAM_ADDR 0x3FFFE/0x3FFFF.
- rst low during HI of a write -> next cycle state IDLE, WE_N=1, DQ=Z, read_data=0; after release with wr_en still high, a fresh 7-cycle transaction runs.
